// File: rtl/bomb_sched_pkg.sv
// Shared constants for the bomb scheduler: LFSR seed/taps, pause key and difficulty step.
package bomb_sched_pkg;
  localparam logic [9:0]  LFSR_SEED     = 10'h1AB;
  // Right-shifting Galois form of x^10 + x^7 + 1
  localparam logic [9:0]  LFSR_TAPS     = 10'h240;
  localparam logic [7:0]  PAUSE_KEY     = 8'h13;
  localparam int unsigned INTERVAL_STEP = 4;
endpackage

// File: rtl/bomb_lfsr10.sv
// Free-running 10-bit Galois LFSR used to pick bomb launch positions.
module bomb_lfsr10
  import bomb_sched_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  output logic [9:0] value
);

  always_ff @(posedge frame_clk) begin
    if (Reset) value <= LFSR_SEED;
    else       value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 10'h000);
  end

endmodule

// File: rtl/bomb_scheduler.sv
// Round-robin bomb launcher with score-driven spawn interval, miss counting and game over.
// Optional pause on keycode 8'h13 when BOMB_SCHED_PAUSE_EN is defined.
module bomb_scheduler
  import bomb_sched_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int BASE_INTERVAL = 60,
  parameter int MIN_INTERVAL  = 12,
  parameter int X_MIN         = 16,
  parameter int X_MAX         = 623,
  parameter int MAX_MISSES    = 3
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 enable,
  input  logic [3:0]           curPoints,
  input  logic [7:0]           keycode,
  input  logic [NUM_SLOTS-1:0] slot_done,
  input  logic [NUM_SLOTS-1:0] slot_caught,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [9:0]           launchX,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [1:0]           misses,
  output logic                 game_over
);

  localparam int         PTR_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [9:0] BASE_I = 10'(BASE_INTERVAL);
  localparam logic [9:0] MIN_I  = 10'(MIN_INTERVAL);

  logic [9:0]           lfsr;
  logic [9:0]           timer;
  logic [PTR_W-1:0]     rr_ptr;
  logic [9:0]           step_amt;
  logic [10:0]          floor_sum;
  logic [9:0]           interval;
  logic                 due;
  logic                 run;
  logic                 fire;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     rr_next;
  logic [NUM_SLOTS-1:0] grant_vec;
  logic [NUM_SLOTS-1:0] clr_vec;
  logic [NUM_SLOTS-1:0] miss_vec;
  logic [3:0]           miss_sum;
  logic [1:0]           miss_next;
  logic [10:0]          raw_x;
  logic [9:0]           x_next;
  logic                 paused;

  bomb_lfsr10 u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .value     (lfsr)
  );

`ifdef BOMB_SCHED_PAUSE_EN
  logic [7:0] key_prev;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      key_prev <= 8'h00;
      paused   <= 1'b0;
    end else begin
      key_prev <= keycode;
      if (game_over)
        paused <= 1'b0;
      else if (keycode == PAUSE_KEY && key_prev != PAUSE_KEY)
        paused <= ~paused;
    end
  end
`else
  logic unused_keycode;
  assign unused_keycode = ^keycode;
  assign paused         = 1'b0;
`endif

  // First free slot at or after ptr, scanning downward so the lowest offset wins.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_SLOTS-1:0] free_v,
                                               input logic [PTR_W-1:0]     ptr);
    logic [NUM_SLOTS-1:0] sh;
    logic [PTR_W-1:0]     pick;
    int                   idx;
    pick = ptr;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_SLOTS;
      sh  = free_v >> idx;
      if (sh[0]) pick = PTR_W'(idx);
    end
    return pick;
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) cnt = cnt + 4'(v[i]);
    return cnt;
  endfunction

  always_comb begin
    step_amt  = 10'(curPoints) * 10'(INTERVAL_STEP);
    floor_sum = {1'b0, step_amt} + {1'b0, MIN_I};
    interval  = (floor_sum >= {1'b0, BASE_I}) ? MIN_I : BASE_I - step_amt;
    due       = (timer >= interval - 10'd1);
    run       = enable & ~game_over & ~paused;
    fire      = run & due & (|(~slot_busy));
    grant_idx = rr_pick(~slot_busy, rr_ptr);
    rr_next   = (grant_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + PTR_W'(1);
    grant_vec = fire ? (NUM_SLOTS'(1) << grant_idx) : '0;
    clr_vec   = slot_busy & (slot_done | slot_caught);
    // Caught wins over done, so a simultaneous pair is not a miss.
    miss_vec  = slot_busy & slot_done & ~slot_caught;
    miss_sum  = {2'b00, misses} + popcount(miss_vec);
    miss_next = (miss_sum >= 4'(MAX_MISSES)) ? 2'(MAX_MISSES) : miss_sum[1:0];
    raw_x     = 11'(X_MIN) + {1'b0, lfsr};
    x_next    = (raw_x > 11'(X_MAX)) ? 10'(raw_x - 11'(X_MAX - X_MIN + 1)) : raw_x[9:0];
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      launch    <= '0;
      launchX   <= 10'(X_MIN);
      slot_busy <= '0;
      misses    <= 2'd0;
      game_over <= 1'b0;
      timer     <= 10'd0;
      rr_ptr    <= '0;
    end else begin
      launch    <= grant_vec;
      slot_busy <= (slot_busy & ~clr_vec) | grant_vec;
      misses    <= miss_next;
      if (miss_next == 2'(MAX_MISSES)) game_over <= 1'b1;
      // A due timer with no free slot simply holds until one frees up.
      if (fire) begin
        timer   <= 10'd0;
        rr_ptr  <= rr_next;
        launchX <= x_next;
      end else if (run && !due) begin
        timer <= timer + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler; pause steps compile only with BOMB_SCHED_PAUSE_EN.
module tb_bomb_scheduler;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic [3:0] curPoints;
  logic [7:0] keycode;
  logic [3:0] slot_done;
  logic [3:0] slot_caught;
  logic [3:0] launch;
  logic [9:0] launchX;
  logic [3:0] slot_busy;
  logic [1:0] misses;
  logic       game_over;

  int errors = 0;
  int checks = 0;
  int n;
  int seen;

  logic [9:0] m_lfsr;
  logic [9:0] m_prev;

  always #5 frame_clk = ~frame_clk;

  bomb_scheduler dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (enable),
    .curPoints   (curPoints),
    .keycode     (keycode),
    .slot_done   (slot_done),
    .slot_caught (slot_caught),
    .launch      (launch),
    .launchX     (launchX),
    .slot_busy   (slot_busy),
    .misses      (misses),
    .game_over   (game_over)
  );

  // Reference LFSR; m_prev holds the value the DUT sees just before each edge.
  always @(posedge frame_clk) begin
    m_prev <= m_lfsr;
    if (Reset) m_lfsr <= 10'h1AB;
    else       m_lfsr <= {1'b0, m_lfsr[9:1]} ^ (m_lfsr[0] ? 10'h240 : 10'h000);
  end

  function automatic logic [9:0] x_of(input logic [9:0] v);
    int r;
    r = 16 + int'(v);
    if (r > 623) r = r - 608;
    return 10'(r);
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_launch(input int max_ticks, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (launch == '0 && cnt < max_ticks);
  endtask

  task automatic quiet(input int k, output int hits);
    hits = 0;
    repeat (k) begin
      tick();
      if (launch != '0) hits++;
    end
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    slot_done   = '0;
    slot_caught = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic check_x(input string name);
    check(name, 32'(launchX), 32'(x_of(m_prev)));
    check({name, "_range"}, 32'(launchX >= 10'd16 && launchX <= 10'd623), 32'd1);
  endtask

  initial begin
    Reset = 1'b1; enable = 1'b0; curPoints = 4'd0; keycode = 8'h00;
    slot_done = '0; slot_caught = '0;

    do_reset();
    check("rst_launch",  32'(launch),    32'h0);
    check("rst_launchX", 32'(launchX),   32'd16);
    check("rst_busy",    32'(slot_busy), 32'h0);
    check("rst_misses",  32'(misses),    32'h0);
    check("rst_gameover",32'(game_over), 32'h0);

    // curPoints=0: interval 60
    enable = 1'b1;
    wait_launch(100, n);
    check("first_gap", n, 32'd60);
    check("first_launch", 32'(launch), 32'b0001);
    check("first_busy", 32'(slot_busy), 32'b0001);
    check_x("first_x");
    wait_launch(100, n);
    check("second_gap", n, 32'd60);
    check("second_launch", 32'(launch), 32'b0010);
    check_x("second_x");

    // curPoints=15 clamps to the 12-frame floor
    curPoints = 4'd15;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_launch(30, n);
      check("fast_gap", n, 32'd12);
      check("fast_launch", 32'(launch), 32'(4'b0001 << k));
    end
    check("all_busy", 32'(slot_busy), 32'b1111);
    quiet(30, seen);
    check("held_no_launch", seen, 32'd0);
    slot_caught = 4'b0100;
    tick();
    slot_caught = '0;
    check("caught_free", 32'(slot_busy), 32'b1011);
    check("freed_not_granted", 32'(launch), 32'h0);
    tick();
    check("refill_launch", 32'(launch), 32'b0100);
    check("refill_busy", 32'(slot_busy), 32'b1111);
    check_x("refill_x");

    // Completions with launches frozen
    enable = 1'b0;
    slot_done = 4'b0010; slot_caught = 4'b0010;
    tick();
    slot_done = '0; slot_caught = '0;
    check("both_busy", 32'(slot_busy), 32'b1101);
    check("both_misses", 32'(misses), 32'h0);
    slot_done = 4'b0010;
    tick();
    slot_done = '0;
    check("idle_busy", 32'(slot_busy), 32'b1101);
    check("idle_misses", 32'(misses), 32'h0);

    // rr_ptr sits at 3; slots 3 and 0 busy, so slot 1 is next
    enable = 1'b1;
    wait_launch(30, n);
    check("rr_launch", 32'(launch), 32'b0010);
    enable = 1'b0;
    check("rr_busy", 32'(slot_busy), 32'b1111);

    // Misses: 0 -> 2, then 2 + 2 saturates at 3
    slot_done = 4'b0011;
    tick();
    slot_done = '0;
    check("miss2", 32'(misses), 32'd2);
    check("miss2_busy", 32'(slot_busy), 32'b1100);
    check("miss2_go", 32'(game_over), 32'h0);
    slot_done = 4'b1100;
    tick();
    slot_done = '0;
    check("miss_sat", 32'(misses), 32'd3);
    check("go_set", 32'(game_over), 32'h1);
    check("go_busy", 32'(slot_busy), 32'h0);
    enable = 1'b1;
    quiet(40, seen);
    check("go_no_launch", seen, 32'd0);
    check("go_sticky", 32'(game_over), 32'h1);
    curPoints = 4'd0;
    do_reset();
    check("rst2_misses", 32'(misses), 32'h0);
    check("rst2_go", 32'(game_over), 32'h0);
    check("rst2_busy", 32'(slot_busy), 32'h0);

    // Raising curPoints past the running count makes the launch due at once
    quiet(20, seen);
    check("pre_cp_quiet", seen, 32'd0);
    curPoints = 4'd12;
    tick();
    check("cp_jump_launch", 32'(launch), 32'b0001);
    wait_launch(30, n);
    check("cp12_gap", n, 32'd12);
    check("cp12_launch", 32'(launch), 32'b0010);

    // Freeze at timer=30: 30 enabled edges of the 60 remain afterwards
    curPoints = 4'd0;
    do_reset();
    quiet(30, seen);
    enable = 1'b0;
    quiet(100, n);
    check("frozen_quiet", seen + n, 32'd0);
    enable = 1'b1;
    wait_launch(100, n);
    check("resume_gap", n, 32'd30);
    check("resume_launch", 32'(launch), 32'b0001);

`ifdef BOMB_SCHED_PAUSE_EN
    curPoints = 4'd15;
    do_reset();
    keycode = 8'h13;
    repeat (5) tick();
    keycode = 8'h00;
    quiet(40, seen);
    check("paused_quiet", seen, 32'd0);
    keycode = 8'h13;
    tick();
    keycode = 8'h00;
    wait_launch(30, n);
    check("unpause_launch", 32'(launch), 32'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
